// File: rtl/tour_pkg.sv
// Knight's-tour definitions shared by the solver and the tour command sequencer:
// command fields, response codes, the one-hot move encoding and sequencer states.
package tour_pkg;

    localparam logic [3:0] MOVE         = 4'h2;
    localparam logic [3:0] MOVE_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLDV,
        HORZ,
        HOLDH
    } tourcmd_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } tour_cmd_t;

    // A knight step in sign/magnitude form; legal is low for any non-one-hot code.
    typedef struct packed {
        logic       legal;
        logic       dx_neg;
        logic [1:0] dx_mag;
        logic       dy_neg;
        logic [1:0] dy_mag;
    } knight_step_t;

    // Field order: legal, dx_neg, dx_mag, dy_neg, dy_mag.
    function automatic knight_step_t decode_move(input logic [7:0] mv);
        knight_step_t s;
        case (mv)
            8'h01:   s = '{1'b1, 1'b1, 2'd1, 1'b0, 2'd2};
            8'h02:   s = '{1'b1, 1'b0, 2'd1, 1'b0, 2'd2};
            8'h04:   s = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd1};
            8'h08:   s = '{1'b1, 1'b1, 2'd2, 1'b1, 2'd1};
            8'h10:   s = '{1'b1, 1'b1, 2'd1, 1'b1, 2'd2};
            8'h20:   s = '{1'b1, 1'b0, 2'd1, 1'b1, 2'd2};
            8'h40:   s = '{1'b1, 1'b0, 2'd2, 1'b0, 2'd1};
            8'h80:   s = '{1'b1, 1'b0, 2'd2, 1'b1, 2'd1};
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/move_decode.sv
// Splits one one-hot knight move into a vertical MOVE leg and a horizontal
// MOVE_FANFARE leg; illegal codes produce zero-square legs heading north.
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    knight_step_t step;
    tour_cmd_t    vert;
    tour_cmd_t    horz;

    always_comb begin
        // NOTE: every field gets a default first so no path infers a latch.
        step = decode_move(move);
        vert = '{opcode: MOVE,         heading: HEAD_N, squares: 4'd0};
        horz = '{opcode: MOVE_FANFARE, heading: HEAD_N, squares: 4'd0};
        if (step.legal) begin
            vert.heading = step.dy_neg ? HEAD_S : HEAD_N;
            vert.squares = {2'b00, step.dy_mag};
            horz.heading = step.dx_neg ? HEAD_W : HEAD_E;
            horz.squares = {2'b00, step.dx_mag};
        end
    end

    assign vert_cmd = vert;
    assign horz_cmd = horz;

endmodule

// File: rtl/tour_cmd.sv
// Tour command sequencer: walks the solved move list leg by leg toward the
// command processor and passes UART commands straight through while idle.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    tourcmd_state_t state_q;
    logic [4:0]     mv_indx_q;
    logic           cmd_rdy_q;

    logic [15:0]    vert_cmd;
    logic [15:0]    horz_cmd;
    logic           last_move;
    logic           horz_leg;

    // The move list is looked up by mv_indx, so the legs follow the live move.
    move_decode u_move_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx_q == LAST_INDX);
    assign horz_leg  = (state_q == HORZ) || (state_q == HOLDH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // transition reads the values from before this edge.
            case (state_q)
                IDLE: begin
                    if (start_tour) begin
                        state_q   <= VERT;
                        mv_indx_q <= '0;
                        cmd_rdy_q <= 1'b1;
                    end
                end
                VERT: begin
                    if (clr_cmd_rdy) begin
                        state_q   <= HOLDV;
                        cmd_rdy_q <= 1'b0;
                    end
                end
                HOLDV: begin
                    if (send_resp) begin
                        state_q   <= HORZ;
                        cmd_rdy_q <= 1'b1;
                    end
                end
                HORZ: begin
                    if (clr_cmd_rdy) begin
                        state_q   <= HOLDH;
                        cmd_rdy_q <= 1'b0;
                    end
                end
                HOLDH: begin
                    if (send_resp) begin
                        if (last_move) begin
                            state_q   <= IDLE;
                            cmd_rdy_q <= 1'b0;
                        end else begin
                            state_q   <= VERT;
                            mv_indx_q <= mv_indx_q + 5'd1;
                            cmd_rdy_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cmd_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (state_q != IDLE) begin
            cmd              = horz_leg ? horz_cmd : vert_cmd;
            cmd_rdy          = cmd_rdy_q;
            clr_cmd_rdy_UART = 1'b0;
            resp             = (horz_leg && last_move) ? RESP_DONE : RESP_ACK;
        end
    end

    assign mv_indx = mv_indx_q;

endmodule
